// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the moore detector: buffered valid/ready load, MSB-first shift-out.
// Optional SER_PARITY_EN appends an even-parity bit after each data word.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 enable,
    output logic                 out_bit,
    output logic                 out_valid,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);

`ifdef SER_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned          BIT_CNT_W = $clog2(FRAME_LEN);
    localparam logic [BIT_CNT_W-1:0] LAST_CNT  = BIT_CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state, state_d;
    logic [BIT_CNT_W-1:0]   cnt, cnt_d;
    logic [FRAME_LEN-1:0]   sreg, sreg_d;
    logic                   out_bit_d, out_valid_d;
    logic [CNT_WIDTH-1:0]   words_d;
    logic                   buf_full;
    logic [WIDTH-1:0]       buf_data;
    logic                   take;

    // Build the on-wire frame from a data word (data MSB first, parity last when enabled)
    function automatic logic [FRAME_LEN-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    assign load_ready = ~buf_full;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and datapath next values; everything holds while enable is low
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sreg_d      = sreg;
        out_valid_d = out_valid;
        words_d     = words_sent;
        take        = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (buf_full) begin
                        take        = 1'b1;
                        sreg_d      = frame_of(buf_data);
                        cnt_d       = LAST_CNT;
                        state_d     = SHIFT;
                        out_valid_d = 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        sreg_d = {sreg[FRAME_LEN-2:0], 1'b0};
                        cnt_d  = cnt - BIT_CNT_W'(1);
                    end else begin
                        words_d = words_sent + CNT_WIDTH'(1);
                        if (buf_full) begin
                            take   = 1'b1;
                            sreg_d = frame_of(buf_data);
                            cnt_d  = LAST_CNT;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        out_bit_d = (state_d == SHIFT) ? sreg_d[FRAME_LEN-1] : IDLE_LEVEL;
    end

    // Shifter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sreg       <= '0;
            out_bit    <= IDLE_LEVEL;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            cnt        <= cnt_d;
            sreg       <= sreg_d;
            out_bit    <= out_bit_d;
            out_valid  <= out_valid_d;
            busy       <= (state_d == SHIFT);
            words_sent <= words_d;
        end
    end

    // One-entry holding buffer; fill and drain are mutually exclusive since fill needs it empty
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full <= 1'b0;
        end else if (take) begin
            buf_full <= 1'b0;
        end else if (load_valid && load_ready) begin
            buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_valid && load_ready) buf_data <= load_data;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard testbench for bit_serializer; honours SER_PARITY_EN for frame length and parity.
module tb_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    logic          clk = 1'b0;
    logic          rst, load_valid, enable;
    logic [W-1:0]  load_data;
    logic          load_ready, out_bit, out_valid, busy;
    logic [15:0]   words_sent;
    logic          load_ready2, out_bit2, out_valid2, busy2;
    logic [1:0]    words_sent2;

    bit exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .enable(enable), .out_bit(out_bit),
        .out_valid(out_valid), .busy(busy), .words_sent(words_sent)
    );

    bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready2),
        .load_data(load_data), .enable(enable), .out_bit(out_bit2),
        .out_valid(out_valid2), .busy(busy2), .words_sent(words_sent2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic apply_reset;
        rst = 1'b1; load_valid = 1'b0; enable = 1'b1; load_data = '0;
        tick;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        apply_reset;
        n_checks += 5;
        if (out_bit !== 1'b0)    begin n_fail++; $display("FAIL reset_out_bit got=%b exp=0", out_bit); end
        if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (words_sent !== 16'd0) begin n_fail++; $display("FAIL reset_words got=%0d exp=0", words_sent); end
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_single;
        int nbits = 0;
        bit e;
        apply_reset;
        load_valid = 1'b1; load_data = 8'hB4; push_word(8'hB4);
        tick;
        load_valid = 1'b0;
        n_checks++;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_full got=%b exp=0", load_ready); end
        for (int c = 0; c < int'(FL) + 3; c++) begin
            tick;
            if (c == 0) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got=%b exp=1", out_valid); end
            end
            if (out_valid === 1'b1) begin
                nbits++;
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_extra_bit got=%b exp=none", out_bit); end
                else begin
                    e = exp_q.pop_front();
                    if (out_bit !== e) begin n_fail++; $display("FAIL single_bit%0d got=%b exp=%b", nbits, out_bit, e); end
                end
            end
        end
        n_checks += 4;
        if (nbits != int'(FL))    begin n_fail++; $display("FAIL single_nbits got=%0d exp=%0d", nbits, FL); end
        if (out_bit !== 1'b0)     begin n_fail++; $display("FAIL single_idle_bit got=%b exp=0", out_bit); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL single_busy got=%b exp=0", busy); end
        if (words_sent !== 16'd1) begin n_fail++; $display("FAIL single_words got=%0d exp=1", words_sent); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] words [3] = '{8'hFF, 8'h00, 8'hA5};
        int idx = 0, nbits = 0;
        bit started = 0, xfer, e;
        apply_reset;
        load_valid = 1'b1; load_data = words[0];
        for (int c = 0; c < 80 && (nbits < 3 * int'(FL) || idx < 3); c++) begin
            xfer = load_valid && load_ready;
            tick;
            if (xfer) begin
                push_word(words[idx]);
                idx++;
                n_checks++;
                if (load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full got=%b exp=0", load_ready); end
                if (idx < 3) load_data = words[idx];
                else load_valid = 1'b0;
            end
            if (started && nbits < 3 * int'(FL)) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap after bit %0d got=%b exp=1", nbits, out_valid); end
            end
            if (out_valid === 1'b1) begin
                started = 1;
                nbits++;
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra_bit got=%b exp=none", out_bit); end
                else begin
                    e = exp_q.pop_front();
                    if (out_bit !== e) begin n_fail++; $display("FAIL b2b_bit%0d got=%b exp=%b", nbits, out_bit, e); end
                end
            end
        end
        tick;
        n_checks += 3;
        if (nbits != 3 * int'(FL)) begin n_fail++; $display("FAIL b2b_nbits got=%0d exp=%0d", nbits, 3 * FL); end
        if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
        if (words_sent !== 16'd3)  begin n_fail++; $display("FAIL b2b_words got=%0d exp=3", words_sent); end
    endtask

    task automatic test_stall;
        int nbits = 0;
        bit e;
        apply_reset;
        load_valid = 1'b1; load_data = 8'hC3; push_word(8'hC3);
        tick;
        load_valid = 1'b0;
        for (int c = 0; c < 10 && nbits < 3; c++) begin
            tick;
            if (out_valid === 1'b1) begin
                nbits++;
                e = exp_q.pop_front();
                n_checks++;
                if (out_bit !== e) begin n_fail++; $display("FAIL stall_pre_bit%0d got=%b exp=%b", nbits, out_bit, e); end
            end
        end
        n_checks++;
        if (nbits != 3) begin n_fail++; $display("FAIL stall_pre_timeout got=%0d exp=3", nbits); end
        enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks += 3;
            if (out_bit !== 1'b0)     begin n_fail++; $display("FAIL stall_frozen_bit got=%b exp=0", out_bit); end
            if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL stall_frozen_valid got=%b exp=1", out_valid); end
            if (words_sent !== 16'd0) begin n_fail++; $display("FAIL stall_words got=%0d exp=0", words_sent); end
        end
        enable = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick;
            if (out_valid === 1'b1) begin
                nbits++;
                e = exp_q.pop_front();
                n_checks++;
                if (out_bit !== e) begin n_fail++; $display("FAIL stall_post_bit%0d got=%b exp=%b", nbits, out_bit, e); end
            end
        end
        tick;
        n_checks += 3;
        if (nbits != int'(FL))    begin n_fail++; $display("FAIL stall_nbits got=%0d exp=%0d", nbits, FL); end
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL stall_idle got=%b exp=0", out_valid); end
        if (words_sent !== 16'd1) begin n_fail++; $display("FAIL stall_words_end got=%0d exp=1", words_sent); end
    endtask

    task automatic test_reset_mid_frame;
        int nbits = 0;
        bit pre, e, buffered = 0;
        apply_reset;
        load_valid = 1'b1; load_data = 8'hF0; push_word(8'hF0);
        tick;
        load_data = 8'h55;
        for (int c = 0; c < 4; c++) begin
            pre = load_valid && load_ready;
            tick;
            if (pre) begin load_valid = 1'b0; buffered = 1; end
            if (out_valid === 1'b1) begin
                nbits++;
                e = exp_q.pop_front();
                n_checks++;
                if (out_bit !== e) begin n_fail++; $display("FAIL rstmid_bit%0d got=%b exp=%b", nbits, out_bit, e); end
            end
        end
        n_checks += 2;
        if (!buffered || nbits != 4) begin n_fail++; $display("FAIL rstmid_setup got=%0d/%0d exp=1/4", buffered, nbits); end
        if (load_ready !== 1'b0)     begin n_fail++; $display("FAIL rstmid_buf_full got=%b exp=0", load_ready); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        n_checks += 5;
        if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        if (out_bit !== 1'b0)     begin n_fail++; $display("FAIL rstmid_bit got=%b exp=0", out_bit); end
        if (load_ready !== 1'b1)  begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", load_ready); end
        if (words_sent !== 16'd0) begin n_fail++; $display("FAIL rstmid_words got=%0d exp=0", words_sent); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        load_valid = 1'b1; load_data = 8'h81; push_word(8'h81);
        tick;
        load_valid = 1'b0;
        nbits = 0;
        for (int c = 0; c < int'(FL) + 3; c++) begin
            tick;
            if (out_valid === 1'b1) begin
                nbits++;
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_extra_bit got=%b exp=none", out_bit); end
                else begin
                    e = exp_q.pop_front();
                    if (out_bit !== e) begin n_fail++; $display("FAIL rstmid_new_bit%0d got=%b exp=%b", nbits, out_bit, e); end
                end
            end
        end
        n_checks += 2;
        if (nbits != int'(FL))    begin n_fail++; $display("FAIL rstmid_nbits got=%0d exp=%0d", nbits, FL); end
        if (words_sent !== 16'd1) begin n_fail++; $display("FAIL rstmid_words_end got=%0d exp=1", words_sent); end
    endtask

    task automatic test_parity;
        logic [FL-1:0] got = '0;
        logic [FL-1:0] exp_v;
        int nbits = 0;
`ifdef SER_PARITY_EN
        exp_v = 9'b0_0000_1111;
`else
        exp_v = 8'b0000_0111;
`endif
        apply_reset;
        load_valid = 1'b1; load_data = 8'h07;
        tick;
        load_valid = 1'b0;
        for (int c = 0; c < int'(FL) + 3; c++) begin
            tick;
            if (out_valid === 1'b1) begin
                nbits++;
                got = {got[FL-2:0], out_bit};
            end
        end
        n_checks += 3;
        if (nbits != int'(FL))  begin n_fail++; $display("FAIL parity_nbits got=%0d exp=%0d", nbits, FL); end
        if (got !== exp_v)      begin n_fail++; $display("FAIL parity_frame got=%b exp=%b", got, exp_v); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL parity_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap;
        int exp_wrap [5] = '{1, 2, 3, 0, 1};
        apply_reset;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1; load_data = W'(8'h10 + k);
            tick;
            load_valid = 1'b0;
            for (int c = 0; c < int'(FL) + 4; c++) tick;
            n_checks += 2;
            if (words_sent2 !== 2'(exp_wrap[k])) begin n_fail++; $display("FAIL wrap_words2[%0d] got=%0d exp=%0d", k, words_sent2, exp_wrap[k]); end
            if (words_sent !== 16'(k + 1))      begin n_fail++; $display("FAIL wrap_words[%0d] got=%0d exp=%0d", k, words_sent, k + 1); end
        end
        n_checks += 4;
        if (out_valid2 !== 1'b0)  begin n_fail++; $display("FAIL wrap_valid2 got=%b exp=0", out_valid2); end
        if (out_bit2 !== 1'b0)    begin n_fail++; $display("FAIL wrap_bit2 got=%b exp=0", out_bit2); end
        if (busy2 !== 1'b0)       begin n_fail++; $display("FAIL wrap_busy2 got=%b exp=0", busy2); end
        if (load_ready2 !== 1'b1) begin n_fail++; $display("FAIL wrap_ready2 got=%b exp=1", load_ready2); end
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; enable = 1'b0; load_data = '0;
        tick;
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_reset_mid_frame;
        test_parity;
        test_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
